// File: rtl/bus_arbiter5.sv
// Round-robin arbiter and select sequencer for the shared five-source bus mux.
// Optional owner timeout/preemption is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter5 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    output logic [4:0] grant,
    output logic [2:0] set,
    output logic       busy,
    output logic       expired
);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] last, last_nxt;
    logic [4:0] grant_nxt;
    logic [2:0] set_nxt;
    logic       busy_nxt;
    logic       expired_nxt;
    logic [4:0] cand;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic       owner_req;
    logic       timeout;
    logic       new_grant;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("bus_arbiter5: MAX_HOLD must be in 1..255");
    end

    // While owned, the current owner is masked out so it never re-wins on its own release/preemption edge.
    assign cand      = (state == IDLE) ? req : (req & ~grant);
    assign owner_req = |(req & grant);

    // NOTE: every variable driven here is given a value before any branch, so no latch can be inferred.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        // Walk the search order backwards so the earliest candidate is the last one written.
        for (int k = 5; k >= 1; k--) begin
            j = (int'(last) + k) % 5;
            if (cand[j]) begin
                pick_vld = 1'b1;
                pick_idx = 3'(j);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       hold_max;

    // True on the edge where this owned cycle brings the count to MAX_HOLD.
    assign hold_max = ({1'b0, hold_cnt} + 9'd1) >= 9'(MAX_HOLD);
    assign timeout  = (state == OWNED) && hold_max && (|cand);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (new_grant || state_nxt == IDLE) begin
            hold_cnt <= '0;
        end else if (state == OWNED) begin
            hold_cnt <= hold_max ? 8'(MAX_HOLD) : hold_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        set_nxt     = set;
        busy_nxt    = busy;
        last_nxt    = last;
        expired_nxt = 1'b0;
        new_grant   = 1'b0;
        case (state)
            IDLE: begin
                new_grant = pick_vld;
            end
            OWNED: begin
                if (!owner_req || timeout) begin
                    if (pick_vld) begin
                        new_grant   = 1'b1;
                        expired_nxt = timeout && owner_req;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = 5'd0;
                        set_nxt   = 3'd0;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 5'd0;
                set_nxt   = 3'd0;
                busy_nxt  = 1'b0;
            end
        endcase
        if (new_grant) begin
            state_nxt = OWNED;
            grant_nxt = 5'b00001 << pick_idx;
            set_nxt   = pick_idx;
            busy_nxt  = 1'b1;
            last_nxt  = pick_idx;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 5'd0;
            set     <= 3'd0;
            busy    <= 1'b0;
            expired <= 1'b0;
            last    <= 3'd4;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            set     <= set_nxt;
            busy    <= busy_nxt;
            expired <= expired_nxt;
            last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter5.sv
// Self-checking bench for bus_arbiter5: vector table, timeout sequences, randomized run vs. model.
// Expectations follow BUS_ARB_TIMEOUT_EN when the bench is compiled with that macro.
module tb_bus_arbiter5;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] req;
    logic [4:0] grant;
    logic [2:0] set;
    logic       busy;
    logic       expired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: owner index (-1 idle), last winner, cycles held.
    int m_owner;
    int m_last;
    int m_held;
    bit m_exp;

    bus_arbiter5 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .set    (set),
        .busy   (busy),
        .expired(expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] req;
        logic [4:0] grant;
        logic [2:0] set;
        logic       busy;
        logic       expired;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic rst, input logic [4:0] r);
        int  win;
        bit  release_now;
        m_exp = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = 4;
            m_held  = 0;
            return;
        end
        if (m_owner < 0) release_now = 1'b1;
        else release_now = !r[m_owner];
`ifdef BUS_ARB_TIMEOUT_EN
        if (!release_now && m_held >= MAX_HOLD && (r & ~(5'b00001 << m_owner)) != 5'd0) begin
            release_now = 1'b1;
            m_exp       = 1'b1;
        end
`endif
        if (!release_now) begin
            m_held++;
            return;
        end
        win = -1;
        for (int k = 1; k <= 5; k++) begin
            int i;
            i = (m_last + k) % 5;
            if (win < 0 && r[i] && i != m_owner) win = i;
        end
        m_owner = win;
        if (win >= 0) begin
            m_last = win;
            m_held = 1;
        end else begin
            m_held = 0;
        end
    endfunction

    // Drive away from the edge, clock once, update the model, then sample just after the edge.
    task automatic apply(input logic rst, input logic [4:0] r);
        @(negedge clk);
        reset = rst;
        req   = r;
        @(posedge clk);
        model_step(rst, r);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [4:0] eg, input logic [2:0] es,
                                 input logic eb, input logic ee);
        check({tag, ".grant"},   32'(grant),   32'(eg));
        check({tag, ".set"},     32'(set),     32'(es));
        check({tag, ".busy"},    32'(busy),    32'(eb));
        check({tag, ".expired"}, 32'(expired), 32'(ee));
    endtask

    task automatic check_model(input string tag);
        logic [4:0] eg;
        logic [2:0] es;
        eg = (m_owner >= 0) ? (5'b00001 << m_owner) : 5'd0;
        es = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check_outputs(tag, eg, es, m_owner >= 0, m_exp);
    endtask

    initial begin
        vec_t       tbl[$];
        logic [4:0] r;
        logic [2:0] es;
        logic       ee;
        logic [31:0] flip;

        reset = 1'b1;
        req   = 5'd0;

        // {rst, req, grant, set, busy, expired}
        tbl.push_back('{1'b1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        // All five requesting, each owner releasing after one cycle: 0,1,2,3,4,0.
        tbl.push_back('{1'b1, 5'b11111, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b11111, 5'b00001, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b11110, 5'b00010, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b11101, 5'b00100, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b11011, 5'b01000, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b10111, 5'b10000, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b01111, 5'b00001, 3'd0, 1'b1, 1'b0});
        // Owner 1, req[3] raised mid-ownership, then owner drops: 1 -> 3 without a bubble.
        tbl.push_back('{1'b1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b00010, 5'b00010, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b01010, 5'b00010, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b01000, 5'b01000, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        // Reset while source 4 owns with everyone requesting; source 0 wins afterwards.
        tbl.push_back('{1'b1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b10000, 5'b10000, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 5'b11111, 5'b00000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b11111, 5'b00001, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});
        // Release with wrap-around: owner 1 drops, 0 is next (search 2,3,4,0).
        tbl.push_back('{1'b0, 5'b00010, 5'b00010, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00001, 5'b00001, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].req);
            check_outputs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].set, tbl[i].busy, tbl[i].expired);
        end

        // Two sources held continuously from reset.
        apply(1'b1, 5'b00000);
        for (int c = 0; c < 20; c++) begin
            apply(1'b0, 5'b00011);
`ifdef BUS_ARB_TIMEOUT_EN
            es = 3'((c / MAX_HOLD) % 2);
            ee = (c > 0) && (c % MAX_HOLD == 0);
`else
            es = 3'd0;
            ee = 1'b0;
`endif
            check_outputs($sformatf("hold%0d", c), 5'b00001 << es, es, 1'b1, ee);
        end

        // Lone owner past MAX_HOLD, then a competitor appears.
        apply(1'b1, 5'b00000);
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 5'b00001);
            check_outputs($sformatf("sat%0d", c), 5'b00001, 3'd0, 1'b1, 1'b0);
        end
        apply(1'b0, 5'b00011);
`ifdef BUS_ARB_TIMEOUT_EN
        check_outputs("sat_preempt", 5'b00010, 3'd1, 1'b1, 1'b1);
`else
        check_outputs("sat_preempt", 5'b00001, 3'd0, 1'b1, 1'b0);
`endif
        apply(1'b0, 5'b00000);
        check_outputs("sat_idle", 5'b00000, 3'd0, 1'b0, 1'b0);

        // Randomized traffic with sticky requests and occasional reset.
        apply(1'b1, 5'b00000);
        check_model("rnd_reset");
        r = 5'd0;
        for (int c = 0; c < 600; c++) begin
            flip = $urandom & $urandom;
            r    = r ^ flip[4:0];
            apply($urandom_range(0, 39) == 0, r);
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
